// File: rtl/seq_max_pkg.sv
// Shared constants and helpers for the sequential frame-maximum tracker.
//   clog2_min1 : index/count width for a frame length (never below 1)
//   ST_ACC / ST_HOLD : tracker state encoding
//   RST_DATA   : reset value of the running maximum
package seq_max_pkg;

  localparam logic ST_ACC  = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  localparam int unsigned RST_DATA = 0;

  // Ceiling log2, clamped to 1 so a one-word frame still has a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/max_ge_cmp.sv
// Unsigned greater-or-equal comparator, a <= ripple carry chain of full-adder
// carry cells computing a + ~b + 1; the final carry is set when a >= b.
//   a, b : N-bit operands
//   ge_c : combinational result, 1 when a >= b
module max_ge_cmp #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ge_c
);

  logic [N-1:0] b_inv;
  logic [N:0]   carry;

  assign b_inv    = ~b;
  assign carry[0] = 1'b1;

  // Full-adder carry cell per bit; the sum bits are not needed.
  for (genvar i = 0; i < int'(N); i++) begin : g_fa
    assign carry[i+1] = (a[i] & b_inv[i]) | (carry[i] & (a[i] ^ b_inv[i]));
  end

  assign ge_c = carry[N];

endmodule

// File: rtl/seq_max_tracker.sv
// Sequential frame-maximum tracker. Accepts LEN-word frames of N-bit words,
// tracks the running maximum and its earliest index with a single reused
// comparator, and presents one (max, idx) result per frame over valid/ready.
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_ready : input word handshake, in_data is the word
//   out_valid/out_ready : result handshake, out_max/out_idx are the result
//   busy              : partial frame accumulated or result pending
// Build option: SEQ_MAX_TRACKER_SIGNED_EN selects two's-complement comparison.
module seq_max_tracker
  import seq_max_pkg::*;
#(
  parameter  int unsigned N    = 8,
  parameter  int unsigned LEN  = 16,
  localparam int unsigned IDXW = clog2_min1(LEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_max,
  output logic [IDXW-1:0] out_idx,
  output logic            busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LEN - 1);

  logic            state_q, state_d;
  logic [IDXW-1:0] count_q, count_d;
  logic [N-1:0]    max_q, max_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    cmp_a, cmp_b;
  logic            ge;

  // Flipping the MSB maps two's-complement order onto unsigned order.
`ifdef SEQ_MAX_TRACKER_SIGNED_EN
  localparam logic [N-1:0] SIGN_MASK = N'(1) << (N - 1);
  assign cmp_a = max_q ^ SIGN_MASK;
  assign cmp_b = in_data ^ SIGN_MASK;
`else
  assign cmp_a = max_q;
  assign cmp_b = in_data;
`endif

  max_ge_cmp #(.N(N)) u_cmp (
    .a    (cmp_a),
    .b    (cmp_b),
    .ge_c (ge)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_ACC;
      count_q     <= '0;
      max_q       <= N'(RST_DATA);
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, running-maximum update and registered output decode.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    max_d   = max_q;
    idx_d   = idx_q;

    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          count_d = IDXW'(count_q + 1'b1);
          if (count_q == '0) begin
            max_d = in_data;
            idx_d = '0;
          end else if (!ge) begin
            // Strictly greater only, so ties keep the earliest index.
            max_d = in_data;
            idx_d = count_q;
          end
          if (count_q == LAST_IDX) begin
            state_d = ST_HOLD;
            count_d = '0;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase

    in_ready_d  = (state_d == ST_ACC);
    out_valid_d = (state_d == ST_HOLD);
    busy_d      = (count_d != '0) || (state_d == ST_HOLD);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_max_tracker.sv
// Directed bench for seq_max_tracker: four instances (LEN 16, 4, 1, 3) share
// clock and reset. A frame-level model (collect words, take argmax with the
// earliest index on ties) is compared against every instance each cycle, and
// literal expectations pin key results.
module tb_seq_max_tracker;

  logic       clk;
  logic       rst;
  logic       iv   [4];
  logic [7:0] id   [4];
  logic       ordy [4];
  logic       ir   [4];
  logic       ov   [4];
  logic       bz   [4];
  logic [7:0] om   [4];
  logic [3:0] idx0;
  logic [1:0] idx1;
  logic [0:0] idx2;
  logic [1:0] idx3;
  int         oi   [4];

  int asserts_cnt;
  int fail_cnt;

  // Model state.
  int lens [4] = '{16, 4, 1, 3};
  int frame [4][16];
  int fcnt [4];
  bit pend [4];
  int emax [4];
  int eidx [4];

  seq_max_tracker #(.N(8), .LEN(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_max(om[0]), .out_idx(idx0), .busy(bz[0]));
  seq_max_tracker #(.N(8), .LEN(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_max(om[1]), .out_idx(idx1), .busy(bz[1]));
  seq_max_tracker #(.N(8), .LEN(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_max(om[2]), .out_idx(idx2), .busy(bz[2]));
  seq_max_tracker #(.N(8), .LEN(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(id[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_max(om[3]), .out_idx(idx3), .busy(bz[3]));

  always_comb begin
    oi[0] = int'(idx0);
    oi[1] = int'(idx1);
    oi[2] = int'(idx2);
    oi[3] = int'(idx3);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    asserts_cnt++;
    if (act != exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Ordering key: two's-complement order when the signed build is selected.
  function automatic int key(input int w);
`ifdef SEQ_MAX_TRACKER_SIGNED_EN
    return w ^ 128;
`else
    return w;
`endif
  endfunction

  function automatic void close_frame(input int k);
    int b;
    b = 0;
    for (int i = 1; i < lens[k]; i++) begin
      if (key(frame[k][i]) > key(frame[k][b])) b = i;
    end
    emax[k] = frame[k][b];
    eidx[k] = b;
    pend[k] = 1'b1;
    fcnt[k] = 0;
  endfunction

  // Transaction-level model, advanced on each clock edge or reset.
  initial begin
    for (int k = 0; k < 4; k++) begin
      fcnt[k] = 0; pend[k] = 1'b0; emax[k] = 0; eidx[k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst);
      for (int k = 0; k < 4; k++) begin
        if (!rst) begin
          fcnt[k] = 0;
          pend[k] = 1'b0;
        end else if (pend[k]) begin
          if (ordy[k]) pend[k] = 1'b0;
        end else if (iv[k]) begin
          frame[k][fcnt[k]] = int'(id[k]);
          fcnt[k]++;
          if (fcnt[k] == lens[k]) close_frame(k);
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("u%0d in_ready", k), int'(ir[k]), int'(!pend[k]));
        chk($sformatf("u%0d out_valid", k), int'(ov[k]), int'(pend[k]));
        chk($sformatf("u%0d busy", k), int'(bz[k]), int'(pend[k] || fcnt[k] != 0));
        if (pend[k]) begin
          chk($sformatf("u%0d out_max", k), int'(om[k]), emax[k]);
          chk($sformatf("u%0d out_idx", k), oi[k], eidx[k]);
        end
      end
    end
  end

  task automatic send(input int k, input logic [7:0] w);
    iv[k] = 1'b1;
    id[k] = w;
    @(negedge clk);
    iv[k] = 1'b0;
  endtask

  task automatic check_result(input string name, input int k, input int m, input int x);
    chk({name, " valid"}, int'(ov[k]), 1);
    chk({name, " max"}, int'(om[k]), m);
    chk({name, " idx"}, oi[k], x);
  endtask

  logic [7:0] pre_words  [5]  = '{8'd255, 8'd200, 8'd100, 8'd50, 8'd1};
  logic [7:0] full_words [16] = '{8'd10, 8'd40, 8'd3, 8'd40, 8'd25, 8'd0, 8'd7, 8'd39,
                                  8'd12, 8'd41, 8'd41, 8'd2, 8'd9, 8'd30, 8'd1, 8'd5};

  initial begin
    asserts_cnt = 0;
    fail_cnt    = 0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0; id[k] = 8'd0; ordy[k] = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset u%0d in_ready", k), int'(ir[k]), 1);
      chk($sformatf("reset u%0d out_valid", k), int'(ov[k]), 0);
      chk($sformatf("reset u%0d out_max", k), int'(om[k]), 0);
      chk($sformatf("reset u%0d out_idx", k), oi[k], 0);
      chk($sformatf("reset u%0d busy", k), int'(bz[k]), 0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Reset mid-frame after 5 of 16 words, then a clean frame.
    for (int i = 0; i < 5; i++) send(0, pre_words[i]);
    chk("midframe busy", int'(bz[0]), 1);
    #2 rst = 1'b0;
    #1;
    chk("async rst in_ready", int'(ir[0]), 1);
    chk("async rst out_valid", int'(ov[0]), 0);
    chk("async rst out_max", int'(om[0]), 0);
    chk("async rst out_idx", oi[0], 0);
    chk("async rst busy", int'(bz[0]), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      chk("fresh frame no early result", int'(ov[0]), 0);
      send(0, full_words[i]);
    end
    check_result("fresh frame", 0, 41, 9);
    @(negedge clk);

    // Basic LEN=4 frame.
    send(1, 8'd3); send(1, 8'd9); send(1, 8'd2); send(1, 8'd7);
    check_result("basic", 1, 9, 1);
    chk("model basic max", emax[1], 9);
    chk("model basic idx", eidx[1], 1);
    @(negedge clk);
    chk("basic in_ready after", int'(ir[1]), 1);

    // Ties keep the earliest index.
    send(1, 8'd5); send(1, 8'd5); send(1, 8'd1); send(1, 8'd5);
    check_result("ties", 1, 5, 0);
    @(negedge clk);

    // Backpressure: result held, inputs ignored.
    ordy[1] = 1'b0;
    send(1, 8'd1); send(1, 8'd2); send(1, 8'd3); send(1, 8'd4);
    for (int c = 0; c < 6; c++) begin
      check_result("backpressure", 1, 4, 3);
      chk("backpressure in_ready", int'(ir[1]), 0);
      iv[1] = 1'b1;
      id[1] = 8'd99;
      @(negedge clk);
    end
    iv[1] = 1'b0;
    check_result("backpressure end", 1, 4, 3);
    ordy[1] = 1'b1;
    @(negedge clk);
    chk("release in_ready", int'(ir[1]), 1);
    send(1, 8'd8); send(1, 8'd0); send(1, 8'd0); send(1, 8'd0);
    check_result("after backpressure", 1, 8, 0);
    @(negedge clk);

    // LEN=1 with idle gaps.
    send(2, 8'd200);
    check_result("len1 first", 2, 200, 0);
    repeat (3) @(negedge clk);
    send(2, 8'd17);
    check_result("len1 second", 2, 17, 0);
    @(negedge clk);

    // Signed versus unsigned ordering.
    send(3, 8'h80); send(3, 8'hFF); send(3, 8'h01);
`ifdef SEQ_MAX_TRACKER_SIGNED_EN
    check_result("signed order", 3, 8'h01, 2);
`else
    check_result("unsigned order", 3, 8'hFF, 1);
`endif
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_cnt, fail_cnt);
    $finish;
  end

endmodule
